// File: rtl/ahb_gpio_responder.sv
// AHB-Lite slave exposing board GPIO: two writable LED banks, synchronised
// slide switches and pushbuttons, and a sticky write-1-to-clear pushbutton
// rising-edge register. Writes take zero wait states; reads take exactly one.
module ahb_gpio_responder #(
    parameter int ADDR_LSB = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    input  logic [17:0] IO_Switch,
    input  logic [4:0]  IO_PB,
    output logic [17:0] IO_LEDR,
    output logic [8:0]  IO_LEDG
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_DATA = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_idx;
    logic        r_hreadyout;
    logic [31:0] r_hrdata;
    logic [17:0] r_ledr;
    logic [8:0]  r_ledg;
    logic [17:0] r_sw_meta;
    logic [17:0] r_sw_sync;
    logic [4:0]  r_pb_meta;
    logic [4:0]  r_pb_sync;
    logic [4:0]  r_pb_prev;
    logic [4:0]  r_pb_edge;
    logic        w_accept;
    logic        w_wr_commit;
    logic [4:0]  w_pb_rise;
    logic [4:0]  w_pb_clr;
    logic [31:0] w_rd_value;
    logic        w_unused_bits;

    // Register-file read view; every field is zero-extended to 32 bits.
    function automatic logic [31:0] read_mux(
        input logic [2:0]  idx,
        input logic [17:0] ledr,
        input logic [8:0]  ledg,
        input logic [17:0] sw,
        input logic [4:0]  pb,
        input logic [4:0]  pb_edge
    );
        logic [31:0] v;
        v = 32'h0000_0000;
        case (idx)
            3'd0:    v = {14'h0000, ledr};
            3'd1:    v = {23'h00_0000, ledg};
            3'd2:    v = {14'h0000, sw};
            3'd3:    v = {27'h000_0000, pb};
            3'd4:    v = {27'h000_0000, pb_edge};
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    // Address, write-data and transfer-type bits outside the decoded fields.
    assign w_unused_bits = ^{HADDR, HWDATA, HTRANS};

    // Transfer acceptance, write commit, edge detect and W1C mask.
    always_comb begin
        w_accept    = HSEL & HTRANS[1] & HREADY & (r_state != ST_RD_WAIT);
        w_wr_commit = (r_state == ST_WR);
        w_pb_rise   = r_pb_sync & ~r_pb_prev;
        w_rd_value  = read_mux(r_idx, r_ledr, r_ledg, r_sw_sync, r_pb_sync, r_pb_edge);
        if (w_wr_commit && (r_idx == 3'd4)) begin
            w_pb_clr = HWDATA[4:0];
        end else begin
            w_pb_clr = 5'b0_0000;
        end
    end

    // Next-state: any ready data-phase cycle may take a new address phase.
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_RD_WAIT: w_next_state = ST_RD_DATA;
            ST_IDLE, ST_WR, ST_RD_DATA: begin
                if (w_accept) begin
                    w_next_state = HWRITE ? ST_WR : ST_RD_WAIT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, pending index and registered bus outputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= ST_IDLE;
            r_idx       <= 3'd0;
            r_hreadyout <= 1'b1;
            r_hrdata    <= 32'h0000_0000;
        end else begin
            r_state     <= w_next_state;
            if (w_accept) begin
                r_idx <= HADDR[ADDR_LSB+2:ADDR_LSB];
            end else begin
                r_idx <= r_idx;
            end
            r_hreadyout <= (w_next_state != ST_RD_WAIT);
            // Read data is captured at the end of the wait state so a write
            // committed just before the read is already visible.
            r_hrdata    <= (w_next_state == ST_RD_DATA) ? w_rd_value : 32'h0000_0000;
        end
    end

    // LED registers, written at the edge that ends a write data phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_ledr <= 18'h0_0000;
            r_ledg <= 9'h000;
        end else if (w_wr_commit && (r_idx == 3'd0)) begin
            r_ledr <= HWDATA[17:0];
        end else if (w_wr_commit && (r_idx == 3'd1)) begin
            r_ledg <= HWDATA[8:0];
        end else begin
            r_ledr <= r_ledr;
            r_ledg <= r_ledg;
        end
    end

    // Two-stage synchronisers for the asynchronous switches and buttons.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_sw_meta <= 18'h0_0000;
            r_sw_sync <= 18'h0_0000;
            r_pb_meta <= 5'b0_0000;
            r_pb_sync <= 5'b0_0000;
            r_pb_prev <= 5'b0_0000;
        end else begin
            r_sw_meta <= IO_Switch;
            r_sw_sync <= r_sw_meta;
            r_pb_meta <= IO_PB;
            r_pb_sync <= r_pb_meta;
            r_pb_prev <= r_pb_sync;
        end
    end

    // Sticky rising-edge flags; a new edge wins over a same-cycle clear.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_pb_edge <= 5'b0_0000;
        end else begin
            r_pb_edge <= (r_pb_edge & ~w_pb_clr) | w_pb_rise;
        end
    end

    assign HRDATA    = r_hrdata;
    assign HREADYOUT = r_hreadyout;
    assign HRESP     = 1'b0;
    assign IO_LEDR   = r_ledr;
    assign IO_LEDG   = r_ledg;

endmodule

// File: tb/tb_ahb_gpio_responder.sv
// Self-checking bench for ahb_gpio_responder: a table of single transfers
// followed by hand-built multi-cycle sequences; read data goes through a
// scoreboard queue filled at address phase and drained at read completion.
module tb_ahb_gpio_responder;

    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [17:0] IO_Switch;
    logic [4:0]  IO_PB;
    logic [17:0] IO_LEDR;
    logic [8:0]  IO_LEDG;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic        wr;
        logic [2:0]  idx;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [17:0] exp_ledr;
        logic [8:0]  exp_ledg;
    } vec_t;

    vec_t vecs[16];

    ahb_gpio_responder #(.ADDR_LSB(2)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .IO_Switch(IO_Switch), .IO_PB(IO_PB), .IO_LEDR(IO_LEDR), .IO_LEDG(IO_LEDG)
    );

    // Single-slave bus: the interconnect ready is this slave's ready.
    assign HREADY = HREADYOUT;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_pop_check(input string nm);
        logic [31:0] e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got read data %h with no expected entry", nm, HRDATA);
        end else begin
            e = sb_q.pop_front();
            check(nm, HRDATA, e);
        end
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = 32'h0;
    endtask

    task automatic addr_phase(input logic wr, input logic [2:0] idx);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HADDR  = {27'h0, idx, 2'b00};
    endtask

    // One isolated transfer; returns at a falling edge after completion.
    task automatic do_xfer(input logic wr, input logic [2:0] idx, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input string nm);
        @(negedge HCLK);
        addr_phase(wr, idx);
        if (!wr) sb_q.push_back(exp_rd);
        @(posedge HCLK);
        @(negedge HCLK);
        bus_idle();
        if (wr) begin
            HWDATA = wdata;
            check({nm, "_wr_ready"}, {31'h0, HREADYOUT}, 32'h1);
            @(posedge HCLK);
            @(negedge HCLK);
            HWDATA = 32'h0;
        end else begin
            HWDATA = 32'h0;
            check({nm, "_rd_wait"}, {31'h0, HREADYOUT}, 32'h0);
            check({nm, "_rd_wait_data"}, HRDATA, 32'h0);
            @(negedge HCLK);
            check({nm, "_rd_ready"}, {31'h0, HREADYOUT}, 32'h1);
            check({nm, "_rd_resp"}, {31'h0, HRESP}, 32'h0);
            sb_pop_check({nm, "_rd_data"});
            @(negedge HCLK);
            check({nm, "_rd_data_cleared"}, HRDATA, 32'h0);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd0, 32'h0002_AAAA, 32'h0,         18'h2AAAA, 9'h000};
        vecs[1]  = '{1'b0, 3'd0, 32'h0,         32'h0002_AAAA, 18'h2AAAA, 9'h000};
        vecs[2]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0,         18'h2AAAA, 9'h1FF};
        vecs[3]  = '{1'b0, 3'd1, 32'h0,         32'h0000_01FF, 18'h2AAAA, 9'h1FF};
        vecs[4]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0,         18'h2AAAA, 9'h1FF};
        vecs[5]  = '{1'b0, 3'd2, 32'h0,         32'h0000_0000, 18'h2AAAA, 9'h1FF};
        vecs[6]  = '{1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0,         18'h2AAAA, 9'h1FF};
        vecs[7]  = '{1'b0, 3'd3, 32'h0,         32'h0000_0000, 18'h2AAAA, 9'h1FF};
        vecs[8]  = '{1'b0, 3'd5, 32'h0,         32'h0000_0000, 18'h2AAAA, 9'h1FF};
        vecs[9]  = '{1'b1, 3'd6, 32'h1234_5678, 32'h0,         18'h2AAAA, 9'h1FF};
        vecs[10] = '{1'b0, 3'd6, 32'h0,         32'h0000_0000, 18'h2AAAA, 9'h1FF};
        vecs[11] = '{1'b0, 3'd7, 32'h0,         32'h0000_0000, 18'h2AAAA, 9'h1FF};
        vecs[12] = '{1'b1, 3'd0, 32'hFFFC_0001, 32'h0,         18'h00001, 9'h1FF};
        vecs[13] = '{1'b0, 3'd0, 32'h0,         32'h0000_0001, 18'h00001, 9'h1FF};
        vecs[14] = '{1'b1, 3'd1, 32'h0000_0155, 32'h0,         18'h00001, 9'h155};
        vecs[15] = '{1'b0, 3'd1, 32'h0,         32'h0000_0155, 18'h00001, 9'h155};

        HRESET = 1'b1;
        bus_idle();
        HWDATA    = 32'h0;
        IO_Switch = 18'h0;
        IO_PB     = 5'h0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_hresp", {31'h0, HRESP}, 32'h0);
        check("rst_ledr", {14'h0, IO_LEDR}, 32'h0);
        check("rst_ledg", {23'h0, IO_LEDG}, 32'h0);
        HRESET = 1'b0;

        // Table of isolated transfers.
        for (int i = 0; i < 16; i++) begin
            do_xfer(vecs[i].wr, vecs[i].idx, vecs[i].wdata, vecs[i].exp_rd, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_ledr", i), {14'h0, IO_LEDR}, {14'h0, vecs[i].exp_ledr});
            check($sformatf("vec%0d_ledg", i), {23'h0, IO_LEDG}, {23'h0, vecs[i].exp_ledg});
        end

        // Back-to-back write then read of LEDR.
        @(negedge HCLK);
        addr_phase(1'b1, 3'd0);
        @(posedge HCLK);
        @(negedge HCLK);
        check("b2b_wr_ready", {31'h0, HREADYOUT}, 32'h1);
        HWDATA = 32'h0002_AAAA;
        addr_phase(1'b0, 3'd0);
        sb_q.push_back(32'h0002_AAAA);
        @(posedge HCLK);
        @(negedge HCLK);
        bus_idle();
        HWDATA = 32'h0;
        check("b2b_ledr", {14'h0, IO_LEDR}, 32'h0002_AAAA);
        check("b2b_rd_wait", {31'h0, HREADYOUT}, 32'h0);
        @(negedge HCLK);
        check("b2b_rd_ready", {31'h0, HREADYOUT}, 32'h1);
        sb_pop_check("b2b_rd_data");

        // IDLE with HSEL=1: no wait state, no data.
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h18;
        @(posedge HCLK);
        @(negedge HCLK);
        check("idle_ready", {31'h0, HREADYOUT}, 32'h1);
        check("idle_hrdata", HRDATA, 32'h0);
        check("idle_hresp", {31'h0, HRESP}, 32'h0);
        // BUSY write and unselected NONSEQ write must not touch LEDR.
        HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 32'h0;
        @(posedge HCLK);
        @(negedge HCLK);
        HWDATA = 32'h0003_FFFF;
        HSEL = 1'b0; HTRANS = 2'b10;
        @(posedge HCLK);
        @(negedge HCLK);
        check("busy_unsel_ready", {31'h0, HREADYOUT}, 32'h1);
        bus_idle();
        @(posedge HCLK);
        @(negedge HCLK);
        HWDATA = 32'h0;
        check("busy_unsel_ledr", {14'h0, IO_LEDR}, 32'h0002_AAAA);

        // Switch change launched together with a read: the read sees old value.
        @(negedge HCLK);
        IO_Switch = 18'h3_0F0F;
        addr_phase(1'b0, 3'd2);
        sb_q.push_back(32'h0);
        @(posedge HCLK);
        @(negedge HCLK);
        bus_idle();
        check("sw_early_wait", {31'h0, HREADYOUT}, 32'h0);
        @(negedge HCLK);
        sb_pop_check("sw_early_data");
        do_xfer(1'b0, 3'd2, 32'h0, 32'h0003_0F0F, "sw_late");

        // Pushbutton pulse leaves a sticky edge flag.
        @(negedge HCLK);
        IO_PB = 5'b0_0100;
        repeat (3) @(negedge HCLK);
        IO_PB = 5'b0_0000;
        repeat (4) @(negedge HCLK);
        do_xfer(1'b0, 3'd4, 32'h0, 32'h0000_0004, "pbedge_set");
        do_xfer(1'b0, 3'd3, 32'h0, 32'h0000_0000, "pb_released");
        do_xfer(1'b1, 3'd4, 32'h0000_0004, 32'h0, "pbedge_w1c");
        do_xfer(1'b0, 3'd4, 32'h0, 32'h0000_0000, "pbedge_cleared");

        // Edge and W1C landing on the same clock edge: the edge wins.
        @(negedge HCLK);
        IO_PB = 5'b0_0100;
        @(posedge HCLK);
        @(negedge HCLK);
        addr_phase(1'b1, 3'd4);
        @(posedge HCLK);
        @(negedge HCLK);
        bus_idle();
        HWDATA = 32'h0000_0004;
        check("coinc_wr_ready", {31'h0, HREADYOUT}, 32'h1);
        @(posedge HCLK);
        @(negedge HCLK);
        HWDATA = 32'h0;
        IO_PB  = 5'b0_0000;
        do_xfer(1'b0, 3'd4, 32'h0, 32'h0000_0004, "coinc_edge_kept");
        repeat (4) @(negedge HCLK);

        // Reset asserted during the read wait state.
        do_xfer(1'b1, 3'd0, 32'h0000_0155, 32'h0, "pre_rst_ledr");
        do_xfer(1'b1, 3'd1, 32'h0000_00AA, 32'h0, "pre_rst_ledg");
        check("pre_rst_ledr_val", {14'h0, IO_LEDR}, 32'h0000_0155);
        @(negedge HCLK);
        addr_phase(1'b0, 3'd0);
        @(posedge HCLK);
        @(negedge HCLK);
        bus_idle();
        check("midrst_wait", {31'h0, HREADYOUT}, 32'h0);
        HRESET = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        check("midrst_ready", {31'h0, HREADYOUT}, 32'h1);
        check("midrst_hrdata", HRDATA, 32'h0);
        check("midrst_hresp", {31'h0, HRESP}, 32'h0);
        check("midrst_ledr", {14'h0, IO_LEDR}, 32'h0);
        check("midrst_ledg", {23'h0, IO_LEDG}, 32'h0);
        HRESET = 1'b0;
        @(negedge HCLK);
        check("postrst_idle_ready", {31'h0, HREADYOUT}, 32'h1);
        check("postrst_idle_hrdata", HRDATA, 32'h0);
        do_xfer(1'b0, 3'd4, 32'h0, 32'h0000_0000, "postrst_pbedge");
        do_xfer(1'b0, 3'd0, 32'h0, 32'h0000_0000, "postrst_ledr");

        check("sb_drained", sb_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_gpio_responder.md
AHB_GPIO_RESPONDER -- requirements
Module: ahb_gpio_responder

Interface
REQ-001 SHALL provide parameter ADDR_LSB, default 2, the lowest HADDR bit used for register select (word addressing).
REQ-002 SHALL provide port HCLK  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL provide port HRESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port HSEL  input  1  slave select.
REQ-005 SHALL provide port HADDR  input  32  address; only HADDR[ADDR_LSB+2:ADDR_LSB] decoded.
REQ-006 SHALL provide port HTRANS  input  2  transfer type; NONSEQ/SEQ when HTRANS[1]=1.
REQ-007 SHALL provide port HWRITE  input  1  1=write, 0=read.
REQ-008 SHALL provide port HREADY  input  1  bus-level ready; qualifies the address phase.
REQ-009 SHALL provide port HWDATA  input  32  write data, valid in data phase.
REQ-010 SHALL provide port HRDATA  output  32  read data.
REQ-011 SHALL provide port HREADYOUT  output  1  slave ready / wait-state control.
REQ-012 SHALL provide port HRESP  output  1  response; tied 0 (OKAY).
REQ-013 SHALL provide port IO_Switch  input  18  asynchronous slide switches.
REQ-014 SHALL provide port IO_PB  input  5  asynchronous pushbuttons, active-high.
REQ-015 SHALL provide port IO_LEDR  output  18  red LEDs.
REQ-016 SHALL provide port IO_LEDG  output  9  green LEDs.

Function
REQ-017 SHALL accept a transfer when HSEL & HTRANS[1] & HREADY at a rising edge, registering register index, HWRITE as the pending data phase.
REQ-018 SHALL ignore IDLE/BUSY transfers and unselected cycles; no register changes, HREADYOUT stays 1.
REQ-019 SHALL decode index 0 LEDR (RW, bits[17:0]), 1 LEDG (RW, bits[8:0]), 2 SW (RO), 3 PB (RO, bits[4:0]), 4 PB_EDGE (RW1C, bits[4:0]); indices 5-7 read 0, writes ignored.
REQ-020 SHALL complete writes with zero wait states: HREADYOUT=1 in the data phase and the register updated from HWDATA at the rising edge ending that data phase.
REQ-021 SHALL complete reads with exactly one wait state: first data-phase cycle HREADYOUT=0, second HREADYOUT=1 with HRDATA valid; state machine IDLE -> RD_WAIT -> RD_DATA -> IDLE or next accepted transfer.
REQ-022 SHALL accept a new address phase during the final data-phase cycle (HREADYOUT=1), supporting back-to-back transfers without idle cycles.
REQ-023 SHALL return read data reflecting any write completed in the immediately preceding data phase (write-then-read same register returns new value).
REQ-024 SHALL zero-extend all read data; unused HRDATA bits 0; HRDATA=0 whenever not in RD_DATA.
REQ-025 SHALL ignore writes to SW and PB; write to read-only index completes with OKAY, zero wait.
REQ-026 SHALL synchronise IO_Switch and IO_PB through two flip-flop stages; SW/PB reads reflect an input change 2 cycles later.
REQ-027 SHALL set PB_EDGE[i] sticky on a 0->1 of synchronised PB[i] (one cycle after PB register change); cleared by writing 1 to bit i.
REQ-028 SHALL give set priority over clear when an edge and a W1C to the same bit coincide.
REQ-029 SHALL drive IO_LEDR/IO_LEDG directly from the LEDR/LEDG registers.
REQ-030 SHALL drive HRESP=0 at all times.

Reset
REQ-031 SHALL, on HRESET=1 at a rising edge, clear LEDR, LEDG, PB_EDGE, all sync and edge flops, pending transfer; state IDLE.
REQ-032 SHALL hold HREADYOUT=1, HRDATA=0, HRESP=0 during and after reset.
REQ-033 SHALL abandon any in-flight transfer when reset is asserted mid-data-phase; no register written.

Verification
REQ-034 Write 0x0002_AAAA to index 0 then read index 0 back-to-back -> IO_LEDR=18'h2AAAA after write edge; read HREADYOUT 0 then 1, HRDATA=0x0002_AAAA.
REQ-035 Write 0xFFFF_FFFF to index 1 -> IO_LEDG=9'h1FF, read returns 0x0000_01FF; write to index 2 -> SW read unchanged.
REQ-036 IO_Switch 0->18'h3_0F0F at cycle N -> SW read sampled from cycle N+2 returns 0x0003_0F0F, earlier returns 0.
REQ-037 Pulse IO_PB[2] high 3 cycles -> PB_EDGE=0x04 persists after release; write 0x04 to index 4 -> reads 0; edge coincident with W1C -> remains 0x04.
REQ-038 Assert HRESET during RD_WAIT with LEDR=0x155 -> next cycle HREADYOUT=1, HRDATA=0, IO_LEDR=0, IO_LEDG=0, PB_EDGE=0.
REQ-039 Read index 6, and HTRANS=IDLE with HSEL=1 -> HRDATA=0, HRESP=0, no wait state for IDLE.
